// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake states, data word, and the
// state encoding used by the instruction/data memory arbiter.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2,
        ERR    = 2'd3
    } arb_state_t;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } grant_t;

    function automatic logic is_grant(input arb_state_t s);
        return (s == IGRANT) || (s == DGRANT);
    endfunction

endpackage

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the instruction
// and data requesters, with a BUSY-cycle watchdog and sticky error state.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        iwait,
    output logic [31:0] iload,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        arb_err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    arb_state_t       r_state;
    grant_t           r_last;
    word_t            r_addr;
    word_t            r_store;
    logic             r_rd;
    logic             r_wr;
    logic [CNT_W-1:0] r_cnt;

    ramstate_t w_rs;
    logic      w_dreq;
    logic      w_req_held;
    logic      w_done;
    logic      w_pick_d;
    logic      w_pick_i;
    logic      w_idone;
    logic      w_ddone;

    assign w_rs   = ramstate_t'(ramstate);
    assign w_dreq = dREN | dWEN;

    // The granted requester must still be asserting for the access to count.
    assign w_req_held = (r_state == IGRANT) ? iREN :
                        (r_state == DGRANT) ? w_dreq : 1'b0;
    assign w_done     = is_grant(r_state) && w_req_held && (w_rs == ACCESS);
    assign w_idone    = w_done && (r_state == IGRANT);
    assign w_ddone    = w_done && (r_state == DGRANT);

    // Data wins unless instruction is also waiting and data went last.
    assign w_pick_d = w_dreq && !(iREN && (r_last == DATA));
    assign w_pick_i = iREN && !w_pick_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_last  <= INSTR;
            r_addr  <= '0;
            r_store <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_d) begin
                        r_state <= DGRANT;
                        r_addr  <= daddr;
                        r_store <= dstore;
                        r_wr    <= dWEN;
                        r_rd    <= ~dWEN;
                        r_cnt   <= '0;
                    end else if (w_pick_i) begin
                        r_state <= IGRANT;
                        r_addr  <= iaddr;
                        r_store <= '0;
                        r_wr    <= 1'b0;
                        r_rd    <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                IGRANT, DGRANT: begin
                    if (w_rs == ERROR) begin
                        r_state <= ERR;
                    end else if (!w_req_held) begin
                        r_state <= IDLE;
                    end else if (w_rs == ACCESS) begin
                        r_state <= IDLE;
                        r_last  <= (r_state == DGRANT) ? DATA : INSTR;
                    end else begin
                        // FREE while granted counts the same as BUSY.
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(MAX_WAIT - 1))
                            r_state <= ERR;
                    end
                end
                ERR: begin
                    r_state <= ERR;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ramREN   = (r_state == IGRANT) || ((r_state == DGRANT) && r_rd);
    assign ramWEN   = (r_state == DGRANT) && r_wr;
    assign ramaddr  = is_grant(r_state) ? r_addr : '0;
    assign ramstore = (r_state == DGRANT) ? r_store : '0;

    assign iwait   = iREN && !w_idone;
    assign dwait   = w_dreq && !w_ddone;
    assign iload   = w_idone ? ramload : '0;
    assign dload   = w_ddone ? ramload : '0;
    assign arb_err = (r_state == ERR);

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: default-parameter instance plus a
// MAX_WAIT=4 instance driven by the same stimulus for the watchdog case.
module tb_memory_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;

    logic        iwait, dwait, ramREN, ramWEN, arb_err;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        iwait4, dwait4, ramREN4, ramWEN4, arb_err4;
    logic [31:0] iload4, dload4, ramaddr4, ramstore4;

    int n_err = 0;
    int n_checks = 0;

    localparam logic [1:0] S_FREE = 2'd0, S_BUSY = 2'd1, S_ACC = 2'd2, S_ERR = 2'd3;

    always #5 CLK = ~CLK;

    memory_arbiter dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .iwait(iwait), .iload(iload), .dwait(dwait),
        .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
    );

    memory_arbiter #(.MAX_WAIT(4)) dut4 (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .iwait(iwait4), .iload(iload4), .dwait(dwait4),
        .dload(dload4), .ramREN(ramREN4), .ramWEN(ramWEN4), .ramaddr(ramaddr4),
        .ramstore(ramstore4), .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err4)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = S_FREE;
        tick; tick;
        settle;
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ramWEN", ramWEN, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_arb_err", arb_err, 0);
        chk("rst_iwait", iwait, 0);

        // Instruction fetch: 2 BUSY then ACCESS
        RST = 0; iREN = 1; iaddr = 32'h40;
        settle;
        chk("i_idle_iwait", iwait, 1);
        chk("i_idle_ramREN", ramREN, 0);
        tick; ramstate = S_BUSY; settle;
        chk("i_c1_ramREN", ramREN, 1);
        chk("i_c1_ramaddr", ramaddr, 32'h40);
        chk("i_c1_iwait", iwait, 1);
        chk("i_c1_iload", iload, 0);
        tick; settle;
        chk("i_c2_ramREN", ramREN, 1);
        chk("i_c2_iwait", iwait, 1);
        tick; ramstate = S_ACC; ramload = 32'h3C010001; settle;
        chk("i_c3_ramREN", ramREN, 1);
        chk("i_c3_iwait", iwait, 0);
        chk("i_c3_iload", iload, 32'h3C010001);
        tick; iREN = 0; ramstate = S_FREE; ramload = 0; settle;
        chk("i_after_ramREN", ramREN, 0);
        chk("i_after_ramaddr", ramaddr, 0);

        // Write with immediate ACCESS
        dWEN = 1; daddr = 32'h80; dstore = 32'hDEADBEEF;
        settle;
        chk("w_idle_dwait", dwait, 1);
        chk("w_idle_ramWEN", ramWEN, 0);
        tick; ramstate = S_ACC; settle;
        chk("w_ramWEN", ramWEN, 1);
        chk("w_ramREN", ramREN, 0);
        chk("w_ramaddr", ramaddr, 32'h80);
        chk("w_ramstore", ramstore, 32'hDEADBEEF);
        chk("w_dwait", dwait, 0);
        tick; dWEN = 0; ramstate = S_FREE; settle;
        chk("w_after_ramWEN", ramWEN, 0);
        chk("w_after_ramstore", ramstore, 0);

        // Contention held from reset: data, then instruction, then data
        RST = 1; iREN = 1; dREN = 1; iaddr = 32'h100; daddr = 32'h200;
        tick; RST = 0; settle;
        chk("c_idle_iwait", iwait, 1);
        chk("c_idle_dwait", dwait, 1);
        tick; ramstate = S_ACC; ramload = 32'h11112222; settle;
        chk("c_d1_ramaddr", ramaddr, 32'h200);
        chk("c_d1_ramREN", ramREN, 1);
        chk("c_d1_dload", dload, 32'h11112222);
        chk("c_d1_dwait", dwait, 0);
        chk("c_d1_iwait", iwait, 1);
        chk("c_d1_iload", iload, 0);
        tick; ramstate = S_FREE; settle;
        chk("c_gap_ramREN", ramREN, 0);
        chk("c_gap_dwait", dwait, 1);
        tick; ramstate = S_ACC; ramload = 32'h33334444; settle;
        chk("c_i_ramaddr", ramaddr, 32'h100);
        chk("c_i_iload", iload, 32'h33334444);
        chk("c_i_iwait", iwait, 0);
        chk("c_i_dload", dload, 0);
        chk("c_i_dwait", dwait, 1);
        tick; ramstate = S_FREE; settle;
        chk("c_gap2_ramREN", ramREN, 0);
        tick; ramstate = S_BUSY; settle;
        chk("c_d2_ramaddr", ramaddr, 32'h200);
        chk("c_d2_dload", dload, 0);

        // Abort: drop dREN after one BUSY cycle
        tick; iREN = 0; dREN = 0; ramstate = S_ACC; ramload = 32'hAAAA5555; settle;
        chk("ab_dload", dload, 0);
        tick; ramstate = S_FREE; settle;
        chk("ab_idle_ramREN", ramREN, 0);
        chk("ab_idle_ramaddr", ramaddr, 0);
        // Abort must not have recorded a data grant, so data still goes first
        iREN = 1; dREN = 1;
        tick; ramstate = S_BUSY; settle;
        chk("ab_rr_ramaddr", ramaddr, 32'h200);

        // Reset mid-access
        RST = 1;
        tick; RST = 0; iREN = 0; dREN = 0; ramstate = S_FREE; settle;
        chk("rm_ramREN", ramREN, 0);
        chk("rm_ramaddr", ramaddr, 0);
        chk("rm_dwait", dwait, 0);

        // RAM ERROR while granted
        dREN = 1; daddr = 32'h300;
        tick; ramstate = S_ERR; settle;
        chk("er_ramREN", ramREN, 1);
        tick; ramstate = S_FREE; settle;
        chk("er_arb_err", arb_err, 1);
        chk("er_ramREN0", ramREN, 0);
        chk("er_ramaddr0", ramaddr, 0);
        chk("er_dwait", dwait, 1);
        RST = 1; dREN = 0;
        tick; RST = 0; settle;
        chk("er_cleared", arb_err, 0);

        // Watchdog: stuck BUSY (one FREE cycle counts as BUSY)
        iREN = 1; iaddr = 32'h44; ramstate = S_BUSY;
        tick; settle;
        chk("to_c1_ramREN4", ramREN4, 1);
        tick; ramstate = S_FREE; settle;
        tick; ramstate = S_BUSY; settle;
        tick; settle;
        chk("to_c4_arb_err4", arb_err4, 0);
        chk("to_c4_ramREN4", ramREN4, 1);
        tick; settle;
        chk("to_err_arb_err4", arb_err4, 1);
        chk("to_err_ramREN4", ramREN4, 0);
        chk("to_err_ramaddr4", ramaddr4, 0);
        chk("to_err_iwait4", iwait4, 1);
        chk("to_def_arb_err", arb_err, 0);
        chk("to_def_ramREN", ramREN, 1);
        for (int k = 0; k < 11; k++) tick;
        settle;
        chk("to_def16_arb_err", arb_err, 0);
        tick; ramstate = S_ACC; ramload = 32'h5A5A5A5A; settle;
        chk("to_def17_arb_err", arb_err, 1);
        chk("to_err_no_iload4", iload4, 0);
        chk("to_err_no_done4", iwait4, 1);
        iREN = 0;
        tick; tick; settle;
        chk("to_sticky4", arb_err4, 1);
        RST = 1;
        tick; RST = 0; ramstate = S_FREE; settle;
        chk("to_rst_arb_err4", arb_err4, 0);
        chk("to_rst_arb_err", arb_err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
